// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one BRAM port between the CPU M-stage and a loader/DMA
// port. A BOOT phase gives the loader exclusive access while the CPU is held
// in reset. In RUN the CPU has priority, and a saturating wait counter lets
// the external port through after MAX_WAIT consecutive lost arbitrations.
module dmem_arbiter #(
    parameter int BOOT_EN  = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    input  logic        ext_req,
    input  logic [3:0]  ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    input  logic        boot_done,
    output logic        cpu_hold,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = (BOOT_EN != 0) ? ST_BOOT : ST_RUN;
    localparam logic [3:0] WAIT_MAX    = 4'(MAX_WAIT);

    state_t     state_q;
    logic       hold_q;
    logic [3:0] wait_q, wait_d;
    logic       rsp_vld_q, rsp_vld_d;
    logic       rsp_ext_q, rsp_ext_d;
    logic       ext_pri;

    // Read data goes straight from the BRAM to the requesters; only the
    // valid strobes are routed here.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    assign ext_pri = (wait_q >= WAIT_MAX);

    // Grant decision: BOOT serves only the loader, RUN favours the CPU unless EXT is starved
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (reset_n) begin
            if (state_q == ST_BOOT) begin
                ext_gnt = ext_req;
            end else if (cpu_req && ext_req) begin
                if (ext_pri) begin
                    ext_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = cpu_req;
                ext_gnt = ext_req;
            end
        end
    end

    // Memory port mux: the granted requester drives the BRAM, otherwise all zero
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    // Next-state for the starvation counter and the response tag
    always_comb begin
        wait_d = 4'd0;
        if ((state_q == ST_RUN) && ext_req && !ext_gnt) begin
            wait_d = ext_pri ? WAIT_MAX : (wait_q + 4'd1);
        end
        rsp_vld_d = (cpu_gnt && (cpu_we == 4'b0000)) ||
                    (ext_gnt && (ext_we == 4'b0000));
        rsp_ext_d = ext_gnt;
    end

    // Boot/run FSM with registered CPU hold; boot_done only matters in BOOT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            hold_q  <= (BOOT_EN != 0);
        end else if ((state_q == ST_BOOT) && boot_done) begin
            state_q <= ST_RUN;
            hold_q  <= 1'b0;
        end
    end

    // Wait counter and {valid, port} response tag; reset drops any read in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q    <= 4'd0;
            rsp_vld_q <= 1'b0;
            rsp_ext_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_ext_q <= rsp_ext_d;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = rsp_vld_q & ~rsp_ext_q;
    assign ext_rvalid = rsp_vld_q & rsp_ext_q;
    assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed boot/latency/starvation/routing/reset
// scenarios followed by protocol-respecting random traffic, all compared
// against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, ext_req, boot_done;
    logic [3:0]  cpu_we, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;

    logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, cpu_hold, mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata;

    logic        cpu_gnt_b, cpu_stall_b, cpu_rvalid_b, ext_gnt_b, ext_rvalid_b, cpu_hold_b, mem_en_b;
    logic [3:0]  mem_we_b;
    logic [31:0] mem_addr_b, mem_wdata_b;

    always #5 clk = ~clk;

    dmem_arbiter #(.BOOT_EN(1), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .boot_done(boot_done), .cpu_hold(cpu_hold),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Second instance without a boot phase, sharing the same stimulus
    dmem_arbiter #(.BOOT_EN(0), .MAX_WAIT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_b), .cpu_stall(cpu_stall_b), .cpu_rvalid(cpu_rvalid_b),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt_b), .ext_rvalid(ext_rvalid_b),
        .boot_done(boot_done), .cpu_hold(cpu_hold_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase, consecutive-loss count, and expected responses by due cycle
    typedef struct {
        int due;
        int port;
    } rsp_t;

    bit   m_boot;
    int   m_lost;
    int   cyc;
    rsp_t m_q[$];
    logic e_cgnt, e_egnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_lost = 0;
        m_q.delete();
    endtask

    // Compute expected outputs for the current cycle and compare everything
    task automatic check_now();
        logic        ecv, erv, een;
        logic [3:0]  ewe;
        logic [31:0] ea, ed;
        #1;
        e_cgnt = 1'b0;
        e_egnt = 1'b0;
        if (reset_n) begin
            if (m_boot) begin
                e_egnt = ext_req;
            end else if (cpu_req && ext_req) begin
                if (m_lost >= MAX_WAIT) e_egnt = 1'b1;
                else                    e_cgnt = 1'b1;
            end else begin
                e_cgnt = cpu_req;
                e_egnt = ext_req;
            end
        end
        ecv = 1'b0;
        erv = 1'b0;
        foreach (m_q[i]) begin
            if (m_q[i].due == cyc) begin
                if (m_q[i].port == 0) ecv = 1'b1;
                else                  erv = 1'b1;
            end
        end
        een = 1'b0; ewe = 4'h0; ea = 32'h0; ed = 32'h0;
        if (e_cgnt) begin
            een = 1'b1; ewe = cpu_we; ea = cpu_addr; ed = cpu_wdata;
        end else if (e_egnt) begin
            een = 1'b1; ewe = ext_we; ea = ext_addr; ed = ext_wdata;
        end
        chk("cpu_gnt",    cpu_gnt,    e_cgnt);
        chk("ext_gnt",    ext_gnt,    e_egnt);
        chk("cpu_stall",  cpu_stall,  cpu_req & ~e_cgnt);
        chk("cpu_rvalid", cpu_rvalid, ecv);
        chk("ext_rvalid", ext_rvalid, erv);
        chk("cpu_hold",   cpu_hold,   m_boot);
        chk("mem_en",     mem_en,     een);
        chk("mem_we",     mem_we,     ewe);
        chk("mem_addr",   mem_addr,   ea);
        chk("mem_wdata",  mem_wdata,  ed);
        chk("b_cpu_hold", cpu_hold_b, 1'b0);
    endtask

    // Clock edge: update the model from this cycle's handshakes
    task automatic advance();
        @(posedge clk);
        if (reset_n) begin
            if (e_cgnt && cpu_we == 4'h0) m_q.push_back('{cyc + 1, 0});
            if (e_egnt && ext_we == 4'h0) m_q.push_back('{cyc + 1, 1});
            if (!m_boot && ext_req && !e_egnt) m_lost = (m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT;
            else                               m_lost = 0;
            if (m_boot && boot_done) m_boot = 1'b0;
        end
        cyc++;
        while (m_q.size() > 0 && m_q[0].due < cyc) void'(m_q.pop_front());
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        ext_req = r; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        reset_n = 1'b0;
        boot_done = 1'b0;
        mem_rdata = 32'h0;
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset state with both requesters active
        set_cpu(1'b1, 4'h0, 32'h40, 32'h0);
        set_ext(1'b1, 4'hF, 32'h0, 32'h13);
        check_now();
        chk("rst_ext_gnt", ext_gnt, 1'b0);
        chk("rst_stall", cpu_stall, 1'b1);
        chk("rst_b_gnt", cpu_gnt_b, 1'b0);
        advance();
        reset_n = 1'b1;

        // Boot load: two loader writes while the CPU is held
        check_now();
        chk("boot_w0_gnt", ext_gnt, 1'b1);
        chk("boot_w0_addr", mem_addr, 32'h0);
        chk("boot_hold", cpu_hold, 1'b1);
        chk("b_first_cpu_gnt", cpu_gnt_b, 1'b1);
        advance();
        set_ext(1'b1, 4'hF, 32'h4, 32'h00A00093);
        check_now();
        chk("boot_w1_gnt", ext_gnt, 1'b1);
        chk("boot_w1_data", mem_wdata, 32'h00A00093);
        chk("boot_cpu_gnt", cpu_gnt, 1'b0);
        advance();
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        boot_done = 1'b1;
        check_now();
        chk("boot_done_stall", cpu_stall, 1'b1);
        advance();
        boot_done = 1'b0;
        check_now();
        chk("run_cpu_gnt", cpu_gnt, 1'b1);
        chk("run_hold", cpu_hold, 1'b0);
        advance();

        // Read latency
        set_cpu(1'b1, 4'h0, 32'h100, 32'h0);
        check_now();
        chk("lat_addr", mem_addr, 32'h100);
        advance();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        check_now();
        chk("lat_rvalid", cpu_rvalid, 1'b1);
        chk("lat_ext_rvalid", ext_rvalid, 1'b0);
        advance();
        check_now();
        chk("lat_rvalid_once", cpu_rvalid, 1'b0);
        advance();

        // Starvation guard
        set_cpu(1'b1, 4'h0, 32'h300, 32'h0);
        set_ext(1'b1, 4'h0, 32'h200, 32'h0);
        for (int i = 0; i < MAX_WAIT; i++) begin
            check_now();
            chk("starve_cpu_gnt", cpu_gnt, 1'b1);
            advance();
        end
        check_now();
        chk("starve_ext_gnt", ext_gnt, 1'b1);
        chk("starve_addr", mem_addr, 32'h200);
        chk("starve_stall", cpu_stall, 1'b1);
        advance();
        set_ext(1'b1, 4'h0, 32'h204, 32'h0);
        check_now();
        chk("starve_cnt_clear", cpu_gnt, 1'b1);
        chk("starve_ext_rvalid", ext_rvalid, 1'b1);
        advance();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        check_now();
        advance();

        // Interleaved routing
        set_cpu(1'b1, 4'h0, 32'h10, 32'h0);
        check_now();
        advance();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_ext(1'b1, 4'h0, 32'h20, 32'h0);
        check_now();
        chk("il_cpu_rv", cpu_rvalid, 1'b1);
        advance();
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        set_cpu(1'b1, 4'h0, 32'h30, 32'h0);
        check_now();
        chk("il_ext_rv", ext_rvalid, 1'b1);
        chk("il_cpu_rv_gap", cpu_rvalid, 1'b0);
        advance();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        check_now();
        chk("il_cpu_rv2", cpu_rvalid, 1'b1);
        advance();

        // Write without response
        set_ext(1'b1, 4'h1, 32'h3, 32'hAB);
        check_now();
        chk("wr_we", mem_we, 4'h1);
        advance();
        set_ext(1'b0, 4'h0, 32'h0, 32'h0);
        check_now();
        chk("wr_no_rv", {cpu_rvalid, ext_rvalid}, 2'b00);
        advance();

        // Reset with a read in flight
        set_cpu(1'b1, 4'h0, 32'h44, 32'h0);
        check_now();
        chk("rmid_gnt", cpu_gnt, 1'b1);
        #1;
        reset_n = 1'b0;
        model_reset();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        check_now();
        advance();
        check_now();
        advance();
        reset_n = 1'b1;
        check_now();
        chk("rmid_no_rv", cpu_rvalid, 1'b0);
        chk("rmid_hold", cpu_hold, 1'b1);
        advance();

        // Random traffic honouring the hold-until-granted rule
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req || e_cgnt)
                set_cpu($urandom_range(0, 3) != 0,
                        ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                        $urandom, $urandom);
            if (!ext_req || e_egnt)
                set_ext($urandom_range(0, 2) != 0,
                        ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                        $urandom, $urandom);
            boot_done = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            if (n == 200) begin
                reset_n = 1'b0;
                model_reset();
                check_now();
                advance();
                reset_n = 1'b1;
            end else begin
                check_now();
                advance();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
